// File: rtl/load_store_unit.sv
// Single-outstanding load/store front end for data_memory.
// Optional request checking: define LSU_ERR_CHECK_EN.
module load_store_unit #(
   parameter int WORDSIZE   = 64,
   parameter int SIZE       = 32,
   parameter int MEM_AW     = 5,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORDSIZE-1:0]   req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [WORDSIZE-1:0]   resp_rdata,
   output logic                  resp_err,
   output logic                  busy,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [WORDSIZE-1:0]   mem_data_input,
   output logic                  mem_write_enable,
   output logic                  mem_read,
   input  logic [WORDSIZE-1:0]   mem_data_output
);

   localparam int OFF_W = $clog2(WORDSIZE / 8);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CAPTURE,
      RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                lat_write;
   logic [MEM_AW-1:0]   lat_idx;
   logic [WORDSIZE-1:0] lat_wdata;
   logic [WORDSIZE-1:0] rdata_q;
   logic                err_q;

   logic [MEM_AW-1:0]   req_idx;
   logic                rej;
   logic                accept;

   assign req_idx = req_addr[OFF_W +: MEM_AW];
   assign accept  = (state == IDLE) && req_valid;

`ifdef LSU_ERR_CHECK_EN
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
      ADDR_WIDTH'((1 << OFF_W) - 1);
   localparam logic [MEM_AW:0] IDX_LIM = (MEM_AW + 1)'(SIZE);

   logic off_bad;
   logic hi_bad;
   logic idx_bad;

   assign off_bad = |(req_addr & OFF_MASK);
   assign hi_bad  = |(req_addr >> (OFF_W + MEM_AW));
   assign idx_bad = {1'b0, req_idx} >= IDX_LIM;
   assign rej     = off_bad | hi_bad | idx_bad;
`else
   // Offset and upper address bits are deliberately dropped here.
   logic unused_addr;
   assign unused_addr = ^req_addr;
   assign rej         = 1'b0;
`endif

   // State register; reset forces IDLE, which also kills any write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and memory strobes, decoded from registered state only.
   always_comb begin
      state_nxt        = state;
      mem_addr         = '0;
      mem_write_enable = 1'b0;
      mem_read         = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               state_nxt = rej ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            mem_addr         = lat_idx;
            mem_write_enable = lat_write;
            mem_read         = !lat_write;
            state_nxt        = lat_write ? RESP : CAPTURE;
         end
         CAPTURE: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request latch and response capture; response fields hold in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_write <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            lat_write <= req_write;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
            rdata_q   <= '0;
            err_q     <= rej;
         end
         if (state == CAPTURE) begin
            rdata_q <= mem_data_output;
         end
      end
   end

   assign req_ready      = (state == IDLE);
   assign resp_valid     = (state == RESP);
   assign busy           = (state != IDLE);
   assign mem_data_input = lat_wdata;
   assign resp_rdata     = rdata_q;
   assign resp_err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plan steps plus random traffic
// against a word-array reference and a behavioural data_memory.
module tb_load_store_unit;

   localparam int WS  = 64;
   localparam int SZ  = 32;
   localparam int AW  = 5;
   localparam int ADW = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           req_valid;
   logic           req_ready;
   logic           req_write;
   logic [ADW-1:0] req_addr;
   logic [WS-1:0]  req_wdata;
   logic           resp_valid;
   logic           resp_ready;
   logic [WS-1:0]  resp_rdata;
   logic           resp_err;
   logic           busy;
   logic [AW-1:0]  mem_addr;
   logic [WS-1:0]  mem_data_input;
   logic           mem_write_enable;
   logic           mem_read;
   logic [WS-1:0]  mem_dout;
   logic           clr;

   int checks = 0;
   int errors = 0;

   logic [WS-1:0] mem [SZ];
   logic [WS-1:0] ref_mem [SZ];

   always #5 clk = ~clk;

   load_store_unit #(
      .WORDSIZE(WS),
      .SIZE(SZ),
      .MEM_AW(AW),
      .ADDR_WIDTH(ADW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .busy(busy),
      .mem_addr(mem_addr),
      .mem_data_input(mem_data_input),
      .mem_write_enable(mem_write_enable),
      .mem_read(mem_read),
      .mem_data_output(mem_dout)
   );

   // data_memory: write on the edge, registered read one cycle later
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < SZ; i++) mem[i] <= '0;
         mem_dout <= '0;
      end else begin
         if (mem_write_enable) mem[mem_addr] <= mem_data_input;
         if (mem_read) mem_dout <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: word = byte address / 8, checked build rejects misuse.
   function automatic void model(input bit w, input logic [15:0] a,
                                 input logic [63:0] d,
                                 output logic [63:0] rd, output bit er,
                                 output int idx, output int lat);
      int word;
      word = int'(a) / 8;
      idx  = word % SZ;
      er   = 1'b0;
`ifdef LSU_ERR_CHECK_EN
      er = (int'(a) % 8 != 0) || (word >= SZ);
`endif
      if (er) begin
         rd  = '0;
         lat = 0;
      end else if (w) begin
         ref_mem[idx] = d;
         rd  = '0;
         lat = 1;
      end else begin
         rd  = ref_mem[idx];
         lat = 2;
      end
   endfunction

   task automatic run(input string tag, input bit w,
                      input logic [15:0] a, input logic [63:0] d,
                      input int hold);
      logic [63:0] e_rd;
      bit          e_er;
      int          e_idx, e_lat;
      int          n, lat, we_n, rd_n;
      logic [63:0] s_addr, s_wd;
      model(w, a, d, e_rd, e_er, e_idx, e_lat);
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      resp_ready = (hold == 0);
      @(negedge clk);
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = {$urandom, $urandom};
      lat = 0;
      we_n = 0;
      rd_n = 0;
      s_addr = '0;
      s_wd = '0;
      while (!resp_valid && lat < 8) begin
         if (mem_write_enable) begin
            we_n++;
            s_addr = 64'(mem_addr);
            s_wd = mem_data_input;
         end
         if (mem_read) begin
            rd_n++;
            s_addr = 64'(mem_addr);
         end
         @(negedge clk);
         lat++;
      end
      req_valid = 1'b0;
      chk({tag, " latency"}, 64'(lat), 64'(e_lat));
      chk({tag, " rdata"}, resp_rdata, e_rd);
      chk({tag, " err"}, 64'(resp_err), 64'(e_er));
      chk({tag, " we_count"}, 64'(we_n), 64'(w && !e_er));
      chk({tag, " rd_count"}, 64'(rd_n), 64'(!w && !e_er));
      if (!e_er) chk({tag, " mem_addr"}, s_addr, 64'(e_idx));
      if (w && !e_er) chk({tag, " mem_wdata"}, s_wd, d);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " hold valid"}, 64'(resp_valid), 64'd1);
         chk({tag, " hold rdata"}, resp_rdata, e_rd);
         chk({tag, " hold err"}, 64'(resp_err), 64'(e_er));
         chk({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
         chk({tag, " hold busy"}, 64'(busy), 64'd1);
         chk({tag, " hold strobes"},
             64'(mem_write_enable | mem_read), 64'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk({tag, " done valid"}, 64'(resp_valid), 64'd0);
      chk({tag, " done req_ready"}, 64'(req_ready), 64'd1);
      chk({tag, " done busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic [63:0] e_rd, k5;
      bit          e_er;
      int          e_idx, e_lat, c;
      logic [15:0] a;

      for (int i = 0; i < SZ; i++) ref_mem[i] = '0;
      rst_n      = 1'b0;
      clr        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst req_ready", 64'(req_ready), 64'd1);
      chk("rst resp_valid", 64'(resp_valid), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst rdata", resp_rdata, 64'd0);
      chk("rst err", 64'(resp_err), 64'd0);
      chk("rst we", 64'(mem_write_enable), 64'd0);
      chk("rst rd", 64'(mem_read), 64'd0);
      chk("rst mem_addr", 64'(mem_addr), 64'd0);
      rst_n = 1'b1;
      clr   = 1'b0;
      @(negedge clk);

      run("t1 store", 1'b1, 16'h0028, 64'hDEADBEEF_CAFEF00D, 0);
      run("t2 load", 1'b0, 16'h0028, 64'd0, 0);
      run("t3 stall", 1'b0, 16'h0028, 64'd0, 5);
      run("t4 offset", 1'b0, 16'h002B, 64'd0, 0);
      run("t4 high", 1'b0, 16'h0100, 64'd0, 0);

      k5 = 64'h0123_4567_89AB_CDEF;
      run("t5 pre", 1'b1, 16'h0010, k5, 0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0010;
      req_wdata = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      req_valid = 1'b0;
      chk("t5 we in access", 64'(mem_write_enable), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5 we async drop", 64'(mem_write_enable), 64'd0);
      chk("t5 ready in rst", 64'(req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5 req_ready", 64'(req_ready), 64'd1);
      chk("t5 resp_valid", 64'(resp_valid), 64'd0);
      chk("t5 busy", 64'(busy), 64'd0);
      run("t5 readback", 1'b0, 16'h0010, 64'd0, 0);

      model(1'b1, 16'h0000, 64'hAAAA_5555_1111_2222,
            e_rd, e_er, e_idx, e_lat);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 16'h0000;
      req_wdata  = 64'hAAAA_5555_1111_2222;
      resp_ready = 1'b1;
      @(negedge clk);
      model(1'b1, 16'h0008, 64'h3333_4444_BBBB_CCCC,
            e_rd, e_er, e_idx, e_lat);
      req_addr  = 16'h0008;
      req_wdata = 64'h3333_4444_BBBB_CCCC;
      c = 1;
      while (!req_ready && c < 10) begin
         @(negedge clk);
         c++;
      end
      chk("t6 issue interval", 64'(c), 64'd3);
      @(negedge clk);
      req_valid = 1'b0;
      c = 0;
      while (!req_ready && c < 10) begin
         @(negedge clk);
         c++;
      end
      chk("t6 second done", 64'(busy), 64'd0);
      run("t6 read0", 1'b0, 16'h0000, 64'd0, 0);
      run("t6 read8", 1'b0, 16'h0008, 64'd0, 0);

      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 3) == 0) a = 16'($urandom);
         else a = {8'h00, 5'($urandom), 3'b000};
         run("rnd", 1'($urandom), a, {$urandom, $urandom},
             int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
